// File: rtl/pg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pg_pkg
// Description : Shared definitions for the profile_gen command sequencer:
//               command opcodes, profile_gen register map, status masks,
//               channel stride and the sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pg_pkg;

  // Command opcodes carried in cmd_op
  localparam logic [1:0] OP_WR_LO   = 2'd0;
  localparam logic [1:0] OP_WR_HI   = 2'd1;
  localparam logic [1:0] OP_WR_BOTH = 2'd2;
  localparam logic [1:0] OP_RUN     = 2'd3;

  // profile_gen per-channel register indices (low 5 address bits)
  localparam logic [4:0] R_STATUS  = 5'd0;
  localparam logic [4:0] R_CTRL    = 5'd1;
  localparam logic [4:0] R_TARGET  = 5'd2;
  localparam logic [4:0] R_VMAX    = 5'd3;
  localparam logic [4:0] R_ACCEL   = 5'd4;
  localparam logic [4:0] R_ABORT_A = 5'd5;

  // profile_gen status register bit masks
  localparam logic [31:0] STATUS_BUSY    = 32'h0000_0001;
  localparam logic [31:0] STATUS_DONE    = 32'h0000_0002;
  localparam logic [31:0] STATUS_ABORTED = 32'h0000_0004;

  // Address distance between consecutive channels
  localparam logic [7:0] CH_STRIDE = 8'h20;

  // FIFO entry: {op[1:0], addr[7:0], data[31:0]}
  localparam int CMD_W = 42;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } seq_state_e;

  // Build a profile_gen register address from channel and register index
  function automatic logic [7:0] reg_addr(input logic [2:0] ch, input logic [4:0] r);
    return {ch, r};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pg_seq_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pg_seq_fifo
// Description : Synchronous command FIFO with flush, occupancy level and
//               full/empty flags. DEPTH must be a power of two (>= 2).
// Revision    : 1.0 - initial release
// ============================================================================
module pg_seq_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 42
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  // Extra pointer bit distinguishes full from empty
  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; flush discards everything including a same-cycle push
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // Pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array, no reset needed since level gates all reads
  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/pg_seq.sv
`default_nettype none
// ============================================================================
// Module      : pg_seq
// Description : Command sequencer in front of profile_gen. Replays queued
//               parameter writes onto the param bus and turns RUN commands
//               into timed trains of acc_step pulses. Aborts are forwarded,
//               flush the queue and trigger a fixed ramp-down step train.
//               Optional macro PG_SEQ_STATS_EN adds steps_total/cmds_total.
// Revision    : 1.0 - initial release
// ============================================================================
module pg_seq
  import pg_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int PERIOD_W    = 16,
  parameter int MIN_PERIOD  = 64,
  parameter int ABORT_STEPS = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [PERIOD_W-1:0]           step_period,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [7:0]                    cmd_addr,
  input  logic [31:0]                   cmd_data,
  input  logic [7:0]                    abort_req,
  input  logic                          clr_flags,
  output logic [7:0]                    pg_param_addr,
  output logic [31:0]                   pg_param_in,
  output logic                          pg_write_hi,
  output logic                          pg_write_lo,
  output logic                          pg_acc_step,
  output logic [7:0]                    pg_abort,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic                          aborted
`ifdef PG_SEQ_STATS_EN
  ,
  output logic [31:0]                   steps_total,
  output logic [31:0]                   cmds_total
`endif
);

  logic             abort_any;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CMD_W-1:0] fifo_rd_data;
  logic [1:0]       head_op;
  logic [7:0]       head_addr;
  logic [31:0]      head_data;
  logic [PERIOD_W-1:0] period_eff;

  seq_state_e          state_q, state_d;
  logic [31:0]         remaining_q, remaining_d;
  logic [PERIOD_W-1:0] div_q, div_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [7:0]          pg_param_addr_q, pg_param_addr_d;
  logic [31:0]         pg_param_in_q, pg_param_in_d;
  logic                pg_write_hi_q, pg_write_hi_d;
  logic                pg_write_lo_q, pg_write_lo_d;
  logic                pg_acc_step_q, pg_acc_step_d;
  logic [7:0]          pg_abort_q, pg_abort_d;
  logic                underrun_q, underrun_d;
  logic                aborted_q, aborted_d;
  logic                underrun_set;

  // A push coinciding with an abort is refused outright so the host sees it dropped
  assign abort_any = |abort_req;
  assign cmd_ready = !fifo_full && !abort_any;
  assign fifo_push = cmd_valid && cmd_ready;
  assign {head_op, head_addr, head_data} = fifo_rd_data;
  assign period_eff = (step_period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : step_period;

  pg_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .wr_data ({cmd_op, cmd_addr, cmd_data}),
    .pop     (fifo_pop),
    .flush   (abort_any),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Next-state, fetch/decode, step divider and abort handling
  always_comb begin
    state_d         = state_q;
    remaining_d     = remaining_q;
    div_d           = div_q;
    period_d        = period_q;
    pg_param_addr_d = pg_param_addr_q;
    pg_param_in_d   = pg_param_in_q;
    pg_write_hi_d   = 1'b0;
    pg_write_lo_d   = 1'b0;
    pg_acc_step_d   = 1'b0;
    pg_abort_d      = abort_req;
    fifo_pop        = 1'b0;
    underrun_set    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable && !fifo_empty && !abort_any) begin
          fifo_pop = 1'b1;
          if (head_op == OP_RUN) begin
            if (head_data != 32'd0) begin
              remaining_d = head_data;
              div_d       = '0;
              period_d    = period_eff;
              state_d     = S_RUN;
            end
          end else begin
            pg_param_addr_d = head_addr;
            pg_param_in_d   = head_data;
            pg_write_lo_d   = (head_op == OP_WR_LO) || (head_op == OP_WR_BOTH);
            pg_write_hi_d   = (head_op == OP_WR_HI) || (head_op == OP_WR_BOTH);
          end
        end
      end
      S_RUN, S_DRAIN: begin
        if (enable) begin
          if (div_q >= period_q - PERIOD_W'(1)) begin
            div_d         = '0;
            period_d      = period_eff;
            pg_acc_step_d = 1'b1;
            remaining_d   = remaining_q - 32'd1;
            if (remaining_q == 32'd1) begin
              state_d = S_IDLE;
              if (state_q == S_RUN && fifo_empty) underrun_set = 1'b1;
            end
          end else begin
            div_d = div_q + PERIOD_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides: ramp-down train with divider phase kept; DRAIN is not reloaded
    if (abort_any) begin
      underrun_set = 1'b0;
      if (state_q != S_DRAIN) begin
        state_d     = S_DRAIN;
        remaining_d = 32'(ABORT_STEPS);
        if (state_q == S_IDLE) period_d = period_eff;
      end
    end

    underrun_d = underrun_set || (underrun_q && !clr_flags);
    aborted_d  = abort_any    || (aborted_q  && !clr_flags);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      remaining_q     <= '0;
      div_q           <= '0;
      period_q        <= PERIOD_W'(MIN_PERIOD);
      pg_param_addr_q <= '0;
      pg_param_in_q   <= '0;
      pg_write_hi_q   <= 1'b0;
      pg_write_lo_q   <= 1'b0;
      pg_acc_step_q   <= 1'b0;
      pg_abort_q      <= '0;
      underrun_q      <= 1'b0;
      aborted_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      remaining_q     <= remaining_d;
      div_q           <= div_d;
      period_q        <= period_d;
      pg_param_addr_q <= pg_param_addr_d;
      pg_param_in_q   <= pg_param_in_d;
      pg_write_hi_q   <= pg_write_hi_d;
      pg_write_lo_q   <= pg_write_lo_d;
      pg_acc_step_q   <= pg_acc_step_d;
      pg_abort_q      <= pg_abort_d;
      underrun_q      <= underrun_d;
      aborted_q       <= aborted_d;
    end
  end

  assign pg_param_addr = pg_param_addr_q;
  assign pg_param_in   = pg_param_in_q;
  assign pg_write_hi   = pg_write_hi_q;
  assign pg_write_lo   = pg_write_lo_q;
  assign pg_acc_step   = pg_acc_step_q;
  assign pg_abort      = pg_abort_q;
  assign underrun      = underrun_q;
  assign aborted       = aborted_q;
  assign busy          = (state_q != S_IDLE) || !fifo_empty;

`ifdef PG_SEQ_STATS_EN
  logic [31:0] steps_total_q, steps_total_d;
  logic [31:0] cmds_total_q, cmds_total_d;

  // Statistics counters; clr_flags zeroes both, a same-cycle event still counts
  always_comb begin
    steps_total_d = clr_flags ? 32'd0 : steps_total_q;
    cmds_total_d  = clr_flags ? 32'd0 : cmds_total_q;
    if (pg_acc_step_d) steps_total_d = steps_total_d + 32'd1;
    if (fifo_pop)      cmds_total_d  = cmds_total_d + 32'd1;
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      steps_total_q <= '0;
      cmds_total_q  <= '0;
    end else begin
      steps_total_q <= steps_total_d;
      cmds_total_q  <= cmds_total_d;
    end
  end

  assign steps_total = steps_total_q;
  assign cmds_total  = cmds_total_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pg_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pg_seq
// Description : Directed self-checking bench for pg_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pg_seq;
  import pg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] step_period;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic [7:0]  abort_req;
  logic        clr_flags;
  logic [7:0]  pg_param_addr;
  logic [31:0] pg_param_in;
  logic        pg_write_hi, pg_write_lo, pg_acc_step;
  logic [7:0]  pg_abort;
  logic        busy;
  logic [4:0]  fifo_level;
  logic        underrun, aborted;
`ifdef PG_SEQ_STATS_EN
  logic [31:0] steps_total, cmds_total;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  pg_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .step_period   (step_period),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_addr      (cmd_addr),
    .cmd_data      (cmd_data),
    .abort_req     (abort_req),
    .clr_flags     (clr_flags),
    .pg_param_addr (pg_param_addr),
    .pg_param_in   (pg_param_in),
    .pg_write_hi   (pg_write_hi),
    .pg_write_lo   (pg_write_lo),
    .pg_acc_step   (pg_acc_step),
    .pg_abort      (pg_abort),
    .busy          (busy),
    .fifo_level    (fifo_level),
    .underrun      (underrun),
    .aborted       (aborted)
`ifdef PG_SEQ_STATS_EN
    ,
    .steps_total   (steps_total),
    .cmds_total    (cmds_total)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [7:0] addr, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
  endtask

  // Cycles until the next acc_step pulse, bounded
  task automatic wait_pulse(input string tag, input int exp_cycles);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (pg_acc_step !== 1'b1 && n < 5000);
    chk(tag, n, exp_cycles);
  endtask

  initial begin
    int pulses;
    int writes;
    rst_n = 1'b0; enable = 1'b0; step_period = 16'd100;
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
    abort_req = '0; clr_flags = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // Reset state
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {pg_write_hi, pg_write_lo, pg_acc_step}, 0);
    chk("rst_abort", pg_abort, 0);
    chk("rst_flags", {underrun, aborted}, 0);

    // Three writes queued, then streamed back to back
    push(OP_WR_LO,   8'h00, 32'd3);
    push(OP_WR_LO,   8'h04, 32'd70);
    push(OP_WR_BOTH, 8'h20, 32'd0);
    chk("wr_level3", fifo_level, 3);
    chk("wr_busy", busy, 1);
    enable = 1'b1;
    step();
    chk("wr1_strobe", {pg_write_hi, pg_write_lo}, 2'b01);
    chk("wr1_addr", pg_param_addr, 8'h00);
    chk("wr1_data", pg_param_in, 32'd3);
    step();
    chk("wr2_strobe", {pg_write_hi, pg_write_lo}, 2'b01);
    chk("wr2_addr", pg_param_addr, 8'h04);
    chk("wr2_data", pg_param_in, 32'd70);
    step();
    chk("wr3_strobe", {pg_write_hi, pg_write_lo}, 2'b11);
    chk("wr3_addr", pg_param_addr, 8'h20);
    chk("wr3_data", pg_param_in, 32'd0);
    chk("wr3_level", fifo_level, 0);
    step();
    chk("wr_idle_strobe", {pg_write_hi, pg_write_lo}, 2'b00);
    chk("wr_hold_addr", pg_param_addr, 8'h20);

    // RUN 3 at period 100
    step_period = 16'd100;
    push(OP_RUN, 8'h00, 32'd3);
    step();
    chk("run_busy", busy, 1);
    wait_pulse("run_p1", 100);
    wait_pulse("run_p2", 100);
    wait_pulse("run_p3", 100);
    chk("run_end_underrun", underrun, 1);
    chk("run_end_busy", busy, 0);
    step();
    chk("run_pulse_width", pg_acc_step, 0);

    // Clamp to MIN_PERIOD
    pulse_clr();
    chk("clr_underrun", underrun, 0);
    step_period = 16'd10;
    push(OP_RUN, 8'h00, 32'd2);
    step();
    wait_pulse("clamp_p1", 64);
    wait_pulse("clamp_p2", 64);
    chk("clamp_underrun", underrun, 1);

    // Abort mid-RUN with writes queued
    pulse_clr();
    push(OP_RUN, 8'h00, 32'd5);
    push(OP_WR_LO, 8'h01, 32'h11);
    push(OP_WR_LO, 8'h02, 32'h22);
    push(OP_WR_HI, 8'h03, 32'h33);
    push(OP_WR_BOTH, 8'h04, 32'h44);
    chk("abt_level4", fifo_level, 4);
    wait_pulse("abt_p1", 61);
    wait_pulse("abt_p2", 64);
    abort_req = 8'h01;
    cmd_valid = 1'b1; cmd_op = OP_WR_LO; cmd_addr = 8'h05; cmd_data = 32'h55;
    #1;
    chk("abt_ready_low", cmd_ready, 0);
    @(posedge clk);
    #1;
    abort_req = 8'h00;
    cmd_valid = 1'b0;
    chk("abt_pg_abort", pg_abort, 8'h01);
    chk("abt_level0", fifo_level, 0);
    chk("abt_flag", aborted, 1);
    step();
    chk("abt_pulse_width", pg_abort, 0);
    pulses = 0;
    writes = 0;
    for (int i = 0; i < 17000; i++) begin
      step();
      if (pg_acc_step) pulses++;
      if (pg_write_hi || pg_write_lo) writes++;
      if (!busy) break;
    end
    chk("drain_pulses", pulses, 256);
    chk("drain_writes", writes, 0);
    chk("drain_busy", busy, 0);
    chk("drain_no_underrun", underrun, 0);

    // Enable pause mid-period
    pulse_clr();
    chk("clr_aborted", aborted, 0);
    step_period = 16'd100;
    push(OP_RUN, 8'h00, 32'd4);
    step();
    wait_pulse("pause_p1", 100);
    repeat (30) step();
    enable = 1'b0;
    pulses = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (pg_acc_step) pulses++;
    end
    chk("pause_no_pulse", pulses, 0);
    chk("pause_busy", busy, 1);
    enable = 1'b1;
    wait_pulse("pause_p2", 70);
    wait_pulse("pause_p3", 100);
    wait_pulse("pause_p4", 100);
    chk("pause_end_busy", busy, 0);
    chk("pause_underrun", underrun, 1);

    // Fill FIFO, overflow push, then reset mid-RUN
    enable = 1'b0;
    push(OP_RUN, 8'h00, 32'd4);
    for (int i = 0; i < 15; i++) push(OP_WR_LO, 8'(i), 32'(i));
    chk("full_level", fifo_level, 16);
    chk("full_ready", cmd_ready, 0);
    push(OP_WR_LO, 8'hAA, 32'hAA);
    chk("full_17th_dropped", fifo_level, 16);
    enable = 1'b1;
    step();
    chk("pop_level", fifo_level, 15);
    chk("pop_ready", cmd_ready, 1);
    repeat (20) step();
    chk("midrun_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_addr", pg_param_addr, 0);
    chk("arst_data", pg_param_in, 0);
    chk("arst_strobes", {pg_write_hi, pg_write_lo, pg_acc_step}, 0);
    chk("arst_abort", pg_abort, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_flags", {underrun, aborted}, 0);
    chk("arst_busy", busy, 0);
    step();
    rst_n = 1'b1;
    pulses = 0;
    writes = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (pg_acc_step) pulses++;
      if (pg_write_hi || pg_write_lo) writes++;
    end
    chk("post_rst_pulses", pulses, 0);
    chk("post_rst_writes", writes, 0);
    chk("post_rst_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
